mio_arbiter: RTL and testbench

Two-requester arbiter for the single memory/IO bus. It shares the bus between the multi-cycle CPU controller (CPU_MIO/MemRead/MemWrite with MIO_ready handshake) and the drawing-board draw engine. Each requester issues one access at a time. The arbiter sequences one bus transaction per grant and returns a one-cycle ready pulse that feeds the CPU's MIO_ready directly. Grants are round-robin, and a timeout guards a hung slave.

---
 rtl/mio_pkg.sv | 20 ++
 rtl/mio_rr_pick.sv | 23 ++
 rtl/mio_arbiter.sv | 152 +++++++++++++++
 tb/tb_mio_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mio_pkg.sv
// Shared encodings for the memory/IO bus arbiter: FSM states, grant codes, abort data.
// Pure declarations, no logic.
package mio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_CPU  = 2'b01,
    GNT_DRW  = 2'b10
  } gnt_t;

  localparam logic [31:0] ABORT_DATA_DFLT = 32'hFFFF_FFFF;
  localparam int          CNT_W           = 8;

endpackage

// File: rtl/mio_rr_pick.sv
// Combinational round-robin choice between CPU and draw engine; zero latency.
// A tie goes to whichever requester was not granted last.
module mio_rr_pick
  import mio_pkg::*;
(
  input  logic       cpu_req,
  input  logic       drw_req,
  input  logic [1:0] last,
  output logic [1:0] pick
);

  always_comb begin
    pick = GNT_NONE;
    if (cpu_req && drw_req) begin
      pick = (last == GNT_CPU) ? GNT_DRW : GNT_CPU;
    end else if (cpu_req) begin
      pick = GNT_CPU;
    end else if (drw_req) begin
      pick = GNT_DRW;
    end
  end

endmodule

// File: rtl/mio_arbiter.sv
// Shares the memory/IO bus between CPU and draw engine, one transaction per grant.
// Request in IDLE at N, ack at N+1 -> ready pulse at N+2; a silent slave is aborted after TIMEOUT cycles.
module mio_arbiter
  import mio_pkg::*;
#(
  parameter int          TIMEOUT    = 16,
  parameter logic [31:0] ABORT_DATA = ABORT_DATA_DFLT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        drw_req,
  input  logic        drw_we,
  input  logic [31:0] drw_addr,
  input  logic [31:0] drw_wdata,
  output logic [31:0] drw_rdata,
  output logic        drw_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [1:0]  grant,
  output logic        err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [1:0]       last, last_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       pick;
  logic [1:0]       grant_nxt;
  logic             mem_req_nxt, mem_we_nxt;
  logic [31:0]      mem_addr_nxt, mem_wdata_nxt;
  logic [31:0]      cpu_rdata_nxt, drw_rdata_nxt, done_data;
  logic             cpu_ready_nxt, drw_ready_nxt, err_nxt;

  mio_rr_pick u_pick (
    .cpu_req (cpu_req),
    .drw_req (drw_req),
    .last    (last),
    .pick    (pick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last      <= GNT_DRW;
      cnt       <= '0;
      grant     <= GNT_NONE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      drw_rdata <= '0;
      cpu_ready <= 1'b0;
      drw_ready <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      cnt       <= cnt_nxt;
      grant     <= grant_nxt;
      mem_req   <= mem_req_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      cpu_rdata <= cpu_rdata_nxt;
      drw_rdata <= drw_rdata_nxt;
      cpu_ready <= cpu_ready_nxt;
      drw_ready <= drw_ready_nxt;
      err       <= err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    last_nxt      = last;
    cnt_nxt       = cnt;
    grant_nxt     = grant;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    cpu_rdata_nxt = cpu_rdata;
    drw_rdata_nxt = drw_rdata;
    cpu_ready_nxt = 1'b0;
    drw_ready_nxt = 1'b0;
    err_nxt       = err;
    done_data     = mem_ack ? mem_rdata : ABORT_DATA;

    case (state)
      IDLE: begin
        if (pick != GNT_NONE) begin
          state_nxt   = ACC;
          grant_nxt   = pick;
          last_nxt    = pick;
          cnt_nxt     = '0;
          mem_req_nxt = 1'b1;
          if (pick == GNT_CPU) begin
            mem_we_nxt    = cpu_we;
            mem_addr_nxt  = cpu_addr;
            mem_wdata_nxt = cpu_wdata;
          end else begin
            mem_we_nxt    = drw_we;
            mem_addr_nxt  = drw_addr;
            mem_wdata_nxt = drw_wdata;
          end
        end
      end

      ACC: begin
        // An ack on the last allowed cycle still counts as a normal completion.
        if (mem_ack || (cnt == CNT_LAST)) begin
          state_nxt   = DONE;
          grant_nxt   = GNT_NONE;
          mem_req_nxt = 1'b0;
          if (!mem_ack) begin
            err_nxt = 1'b1;
          end
          if (grant == GNT_CPU) begin
            cpu_ready_nxt = 1'b1;
            if (!mem_we) cpu_rdata_nxt = done_data;
          end else begin
            drw_ready_nxt = 1'b1;
            if (!mem_we) drw_rdata_nxt = done_data;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      // Requests are ignored here: the CPU keeps its request high through the ready cycle.
      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mio_arbiter.sv
// Randomized scoreboard bench for mio_arbiter: agents issue accesses and push predictions,
// a slave model answers the bus, and a monitor checks every completion and every grant.
module tb_mio_arbiter;

  localparam int          TIMEOUT = 16;
  localparam logic [31:0] ABORT   = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_ready;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        drw_req, drw_we, drw_ready;
  logic [31:0] drw_addr, drw_wdata, drw_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  grant;
  logic        err;

  always #5 clk = ~clk;

  mio_arbiter #(.TIMEOUT(TIMEOUT), .ABORT_DATA(ABORT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .drw_req(drw_req), .drw_we(drw_we), .drw_addr(drw_addr), .drw_wdata(drw_wdata),
    .drw_rdata(drw_rdata), .drw_ready(drw_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .grant(grant), .err(err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          len;
    logic        abort;
  } exp_t;

  exp_t        exp_q0[$], exp_q1[$];
  int          lat_q0[$], lat_q1[$];
  logic [31:0] mmem[logic [31:0]];
  logic [31:0] smem[logic [31:0]];
  logic [31:0] rd_hold[2];
  int          n_cmp = 0, n_bad = 0;
  logic        mon_en = 1'b0;
  logic [1:0]  req_q = 2'b00;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic drive(input int id, input logic rq, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (id == 0) begin
      cpu_req = rq; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end else begin
      drw_req = rq; drw_we = we; drw_addr = addr; drw_wdata = wdata;
    end
  endtask

  task automatic drop(input int id);
    if (id == 0) cpu_req = 1'b0;
    else         drw_req = 1'b0;
  endtask

  function automatic logic rdy_of(input int id);
    return (id == 0) ? cpu_ready : drw_ready;
  endfunction

  // Issue one access: predict the outcome, hand the slave its latency, then handshake.
  task automatic do_txn(input int id, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int lat);
    exp_t        e;
    int          n;
    logic [31:0] cur;
    logic [1:0]  mine;
    mine    = (id == 0) ? 2'b01 : 2'b10;
    cur     = mmem.exists(addr) ? mmem[addr] : dflt(addr);
    e.we    = we;
    e.addr  = addr;
    e.wdata = wdata;
    e.abort = (lat >= TIMEOUT);
    e.len   = e.abort ? TIMEOUT : lat + 1;
    if (!we) rd_hold[id] = e.abort ? ABORT : cur;
    if (we && !e.abort) mmem[addr] = wdata;
    e.rdata = rd_hold[id];
    if (id == 0) begin exp_q0.push_back(e); lat_q0.push_back(lat); end
    else         begin exp_q1.push_back(e); lat_q1.push_back(lat); end
    drive(id, 1'b1, we, addr, wdata);
    n = 0;
    @(negedge clk);
    while (grant != mine && n < 300) begin @(negedge clk); n++; end
    if (grant != mine) begin bound_fail("wait_grant"); drop(id); return; end
    drive(id, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
    n = 0;
    @(negedge clk);
    while (!rdy_of(id) && n < 60) begin @(negedge clk); n++; end
    if (!rdy_of(id)) begin bound_fail("wait_ready"); drop(id); end
  endtask

  task automatic run_agent(input int id, input int cnt, input bit fast);
    int          lat, gap, r;
    logic [31:0] base;
    base = (id == 0) ? 32'h0000_0000 : 32'hC000_0000;
    for (int i = 0; i < cnt; i++) begin
      r   = int'($urandom_range(0, 19));
      lat = (r < 12) ? int'($urandom_range(0, 3)) : (r < 14) ? TIMEOUT - 1 :
            (r < 16) ? TIMEOUT : int'($urandom_range(4, 9));
      gap = int'($urandom_range(0, 3));
      if (fast) begin lat = 0; gap = 0; end
      do_txn(id, 1'($urandom_range(0, 1)), base + 4 * $urandom_range(0, 7), $urandom, lat);
      if (gap > 0) begin drop(id); repeat (gap) @(negedge clk); end
    end
    drop(id);
  endtask

  always @(posedge clk) req_q <= {drw_req, cpu_req};

  // Slave: acks after the latency the issuing agent chose; stray acks while idle.
  initial begin
    int idx, lat;
    idx = 0; lat = 0;
    mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        idx = 0; mem_ack = 1'b0;
      end else if (mem_req) begin
        if (idx == 0) begin
          lat = 0;
          if (grant == 2'b01 && lat_q0.size() > 0) lat = lat_q0.pop_front();
          if (grant == 2'b10 && lat_q1.size() > 0) lat = lat_q1.pop_front();
        end
        if (idx == lat) begin
          mem_ack = 1'b1;
          if (mem_we) smem[mem_addr] = mem_wdata;
          else mem_rdata = smem.exists(mem_addr) ? smem[mem_addr] : dflt(mem_addr);
        end else begin
          mem_ack = 1'b0; mem_rdata = $urandom;
        end
        idx++;
      end else begin
        idx = 0;
        mem_ack = ($urandom_range(0, 5) == 0);
        mem_rdata = $urandom;
      end
    end
  end

  // Monitor: grant order, bus field stability, and per-completion scoreboard checks.
  initial begin
    logic [1:0]  prev_grant, prev_rdy, rdy;
    logic        prev_mem_req, cap_we, frozen, err_exp;
    logic [31:0] cap_addr, cap_wdata;
    int          cap_id, acc_len, last_w, w;
    exp_t        e;
    prev_grant = '0; prev_rdy = '0; prev_mem_req = 1'b0; err_exp = 1'b0;
    cap_we = 1'b0; cap_addr = '0; cap_wdata = '0; cap_id = 0; acc_len = 0;
    frozen = 1'b1; last_w = 1;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        rdy = {drw_ready, cpu_ready};
        if (grant != 2'b00 && prev_grant == 2'b00) begin
          w = (req_q == 2'b11) ? 1 - last_w : (req_q == 2'b01) ? 0 : (req_q == 2'b10) ? 1 : -1;
          chk("grant_rr", {30'd0, grant}, (w == 0) ? 32'd1 : (w == 1) ? 32'd2 : 32'd0);
          chk("grant_gap", {30'd0, prev_rdy}, 32'd0);
          if (w >= 0) last_w = w;
        end
        if (mem_req && !prev_mem_req) begin
          cap_we = mem_we; cap_addr = mem_addr; cap_wdata = mem_wdata;
          cap_id = (grant == 2'b10) ? 1 : 0;
          acc_len = 1; frozen = 1'b1;
        end else if (mem_req) begin
          acc_len++;
          if (mem_we !== cap_we || mem_addr !== cap_addr || mem_wdata !== cap_wdata) frozen = 1'b0;
        end
        if (rdy == 2'b11) chk("ready_both", {30'd0, rdy}, 32'd1);
        for (int id = 0; id < 2; id++) begin
          if (rdy[id]) begin
            chk("ready_single_cycle", {31'd0, prev_rdy[id]}, 32'd0);
            if ((id == 0 && exp_q0.size() == 0) || (id == 1 && exp_q1.size() == 0)) begin
              bound_fail("scoreboard_empty");
            end else begin
              e = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
              if (e.abort) err_exp = 1'b1;
              chk("ready_owner", cap_id, id);
              chk("bus_we", {31'd0, cap_we}, {31'd0, e.we});
              chk("bus_addr", cap_addr, e.addr);
              if (e.we) chk("bus_wdata", cap_wdata, e.wdata);
              chk("bus_frozen", {31'd0, frozen}, 32'd1);
              chk("acc_len", acc_len, e.len);
              chk("rdata", (id == 0) ? cpu_rdata : drw_rdata, e.rdata);
              chk("err", {31'd0, err}, {31'd0, err_exp});
            end
          end
        end
        prev_grant = grant; prev_rdy = rdy; prev_mem_req = mem_req;
      end
    end
  end

  initial begin
    int n;
    rd_hold[0] = '0; rd_hold[1] = '0;
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_ready", {30'd0, drw_ready, cpu_ready}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    smem[32'h10] = 32'h1234_5678;
    mmem[32'h10] = 32'h1234_5678;
    do_txn(0, 1'b0, 32'h0000_0010, 32'h0, 3);
    drop(0); @(negedge clk);
    do_txn(1, 1'b1, 32'hC000_0100, 32'hA5A5_A5A5, 2);
    drop(1); @(negedge clk);
    do_txn(0, 1'b0, 32'h0000_0018, 32'h0, TIMEOUT - 1);
    chk("err_after_edge_ack", {31'd0, err}, 32'd0);
    drop(0); @(negedge clk);
    do_txn(0, 1'b0, 32'h0000_0014, 32'h0, TIMEOUT);
    chk("err_after_timeout", {31'd0, err}, 32'd1);
    drop(0); @(negedge clk);
    do_txn(0, 1'b0, 32'h0000_0010, 32'h0, 1);
    drop(0); @(negedge clk);

    fork
      run_agent(0, 4, 1'b1);
      run_agent(1, 4, 1'b1);
    join
    @(negedge clk);
    fork
      run_agent(0, 25, 1'b0);
      run_agent(1, 25, 1'b0);
    join
    repeat (3) @(negedge clk);
    chk("sb_drain", exp_q0.size() + exp_q1.size(), 32'd0);

    mon_en = 1'b0;
    lat_q0.push_back(TIMEOUT + 4);
    lat_q1.push_back(TIMEOUT + 4);
    drive(0, 1'b1, 1'b0, 32'h0000_0020, '0);
    drive(1, 1'b1, 1'b0, 32'hC000_0020, '0);
    n = 0;
    @(negedge clk);
    while (!mem_req && n < 50) begin @(negedge clk); n++; end
    if (!mem_req) bound_fail("rst_wait_acc");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("midrst_grant", {30'd0, grant}, 32'd0);
    chk("midrst_ready", {30'd0, drw_ready, cpu_ready}, 32'd0);
    chk("midrst_err", {31'd0, err}, 32'd0);
    chk("midrst_cpu_rdata", cpu_rdata, 32'd0);
    chk("midrst_drw_rdata", drw_rdata, 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    lat_q0.delete();
    lat_q1.delete();
    @(negedge clk);
    chk("midrst_no_ready", {30'd0, drw_ready, cpu_ready}, 32'd0);
    reset = 1'b1;
    n = 0;
    @(negedge clk);
    while (grant == 2'b00 && n < 10) begin @(negedge clk); n++; end
    chk("rst_first_tie", {30'd0, grant}, 32'd1);
    n = 0;
    while (!cpu_ready && n < 40) begin @(negedge clk); n++; end
    chk("rst_reissue_ready", {31'd0, cpu_ready}, 32'd1);
    drop(0); drop(1);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
